// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op encodings, default widths and
// the forwarding-select constant for "take the register file".
package cpu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int AW_DEFAULT = 5;
  localparam int FWD_RF     = 0;

  // Any op that touches HI/LO and therefore must wait for the unit.
  function automatic logic md_uses_unit(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  // Ops that launch a multi-cycle computation.
  function automatic logic md_is_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// HI/LO unit busy countdown: loads the op latency on start, counts down to
// zero, and is cleared by cancel ahead of any load or decrement.
module md_busy_ctr #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cancel) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/e_hazard_unit.sv
// Execute-stage hazard unit: youngest-writer forwarding select over NSRC
// producer stages, load-use/md-busy stall, and a saturating stall counter.
module e_hazard_unit
  import cpu_pkg::*;
#(
  parameter int NSRC    = 2,
  parameter int AW      = AW_DEFAULT,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CW      = 32,
  parameter int SW      = $clog2(NSRC + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rs_E,
  input  logic [AW-1:0]     rt_E,
  input  logic              use_rs_E,
  input  logic              use_rt_E,
  input  logic              valid_E,
  input  logic [3:0]        md_op_E,
  input  logic [NSRC*AW-1:0] prod_addr,
  input  logic [NSRC*TW-1:0] prod_tnew,
  input  logic              md_cancel,
  output logic [SW-1:0]     fwd_rs_sel,
  output logic [SW-1:0]     fwd_rt_sel,
  output logic              stall_E,
  output logic              md_busy,
  output logic              md_start,
  output logic [CW-1:0]     stall_cnt
);

  logic [NSRC-1:0] rs_hit, rt_hit, prod_rdy;
  logic            hz_rs, hz_rt, md_hz;

  genvar k;
  generate
    for (k = 0; k < NSRC; k++) begin : g_src
      assign rs_hit[k]   = (rs_E != '0) && (prod_addr[k*AW +: AW] == rs_E);
      assign rt_hit[k]   = (rt_E != '0) && (prod_addr[k*AW +: AW] == rt_E);
      assign prod_rdy[k] = (prod_tnew[k*TW +: TW] == '0);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match is the last one written;
  // a not-ready young writer masks any older ready copy.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value held and no latch is inferred.
  always_comb begin
    fwd_rs_sel = SW'(FWD_RF);
    fwd_rt_sel = SW'(FWD_RF);
    hz_rs      = 1'b0;
    hz_rt      = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (rs_hit[i]) begin
        fwd_rs_sel = prod_rdy[i] ? SW'(i + 1) : SW'(FWD_RF);
        hz_rs      = !prod_rdy[i] && use_rs_E;
      end
      if (rt_hit[i]) begin
        fwd_rt_sel = prod_rdy[i] ? SW'(i + 1) : SW'(FWD_RF);
        hz_rt      = !prod_rdy[i] && use_rt_E;
      end
    end
  end

  assign md_hz    = valid_E && md_uses_unit(md_op_E) && md_busy;
  assign stall_E  = valid_E && (hz_rs || hz_rt || md_hz);
  assign md_start = valid_E && md_is_start(md_op_E) && !stall_E && !md_cancel;

  md_busy_ctr #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_ctr (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div(md_op_E)),
    .cancel (md_cancel),
    .busy   (md_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_E && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule
